// File: rtl/lcd_display_sequencer.sv
// HD44780-style display front-end: one-time init sequence, then frame refreshes from an internal
// character buffer, with an optional blinking cursor cell and periodic or on-demand frames.
module lcd_display_sequencer #(
   parameter int unsigned CLK_HZ             = 50000000,
   parameter int unsigned COLS               = 16,
   parameter int unsigned ROWS               = 2,
   parameter int unsigned CLEAR_WAIT_US      = 1640,
   parameter int unsigned REFRESH_MS         = 1000,
   parameter logic [7:0]  CURSOR_CHAR        = 8'h23,
   parameter bit          REINIT_EVERY_FRAME = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          periodic,
   input  logic                          refresh_req,
   input  logic                          blink_en,
   input  logic [$clog2(ROWS*COLS)-1:0]  cursor_pos,
   input  logic                          wr_en,
   input  logic [$clog2(ROWS*COLS)-1:0]  wr_addr,
   input  logic [7:0]                    wr_data,
   input  logic                          done,
   output logic                          next_instruction,
   output logic [9:0]                    db,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int unsigned CELLS       = ROWS * COLS;
   localparam int unsigned AW          = $clog2(CELLS);
   localparam int unsigned CLEAR_CYC   = CLK_HZ / 1000000 * CLEAR_WAIT_US;
   localparam int unsigned REFRESH_CYC = CLK_HZ / 1000 * REFRESH_MS;
   localparam int unsigned CLR_W       = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
   localparam int unsigned REF_W       = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam int unsigned CLR_LAST    = (CLEAR_CYC > 0) ? CLEAR_CYC - 1 : 0;
   localparam int unsigned REF_LAST    = (REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0;
   localparam int unsigned RW_W        = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW_W        = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_FUNCTION_SET, S_ENTRY_MODE_SET, S_DISPLAY_ON_OFF, S_CLEAR_DISPLAY,
      S_WAIT_CLEAR, S_SET_ADDR, S_WRITE_CHAR, S_FRAME_END, S_FRAME_WAIT
   } state_t;

   state_t            state, state_n;
   logic [RW_W-1:0]   row, row_n;
   logic [CW_W-1:0]   col, col_n;
   logic [CLR_W-1:0]  clr_cnt, clr_cnt_n;
   logic [REF_W-1:0]  ref_cnt, ref_cnt_n;
   logic              init_done, init_done_n;
   logic              pending, pending_n;
   logic              phase, phase_n;
   logic [9:0]        db_n;
   logic              ni_n, busy_n, fd_n;
   logic              accept, start, issue;
   logic [AW-1:0]     idx_n;
   logic [7:0]        char_n;
   logic [6:0]        base_n;

   logic [7:0] mem [CELLS];

   // Character buffer; out-of-range addresses are dropped
   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < CELLS)) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         row              <= '0;
         col              <= '0;
         clr_cnt          <= '0;
         ref_cnt          <= '0;
         init_done        <= 1'b0;
         pending          <= 1'b0;
         phase            <= 1'b1;
         db               <= '0;
         next_instruction <= 1'b0;
         busy             <= 1'b0;
         frame_done       <= 1'b0;
      end else begin
         state            <= state_n;
         row              <= row_n;
         col              <= col_n;
         clr_cnt          <= clr_cnt_n;
         ref_cnt          <= ref_cnt_n;
         init_done        <= init_done_n;
         pending          <= pending_n;
         phase            <= phase_n;
         db               <= db_n;
         next_instruction <= ni_n;
         busy             <= busy_n;
         frame_done       <= fd_n;
      end
   end

   always_comb begin
      state_n     = state;
      row_n       = row;
      col_n       = col;
      clr_cnt_n   = '0;
      ref_cnt_n   = '0;
      init_done_n = init_done;
      pending_n   = pending | refresh_req;
      phase_n     = phase;
      start       = 1'b0;
      // a done coinciding with our own pulse cannot belong to that pulse
      accept      = done & ~next_instruction;

      case (state)
         S_IDLE:           if (enable) state_n = init_done ? S_FRAME_WAIT : S_FUNCTION_SET;
         S_FUNCTION_SET:   if (accept) state_n = S_ENTRY_MODE_SET;
         S_ENTRY_MODE_SET: if (accept) state_n = S_DISPLAY_ON_OFF;
         S_DISPLAY_ON_OFF: if (accept) state_n = S_CLEAR_DISPLAY;
         S_CLEAR_DISPLAY:  if (accept) state_n = S_WAIT_CLEAR;
         S_WAIT_CLEAR: begin
            if (clr_cnt == CLR_W'(CLR_LAST)) begin
               init_done_n = 1'b1;
               state_n     = S_SET_ADDR;
            end else begin
               clr_cnt_n = clr_cnt + CLR_W'(1);
            end
         end
         S_SET_ADDR:       if (accept) state_n = S_WRITE_CHAR;
         S_WRITE_CHAR: begin
            if (accept) begin
               if (col == CW_W'(COLS - 1)) begin
                  col_n = '0;
                  if (row == RW_W'(ROWS - 1)) begin
                     row_n   = '0;
                     state_n = S_FRAME_END;
                  end else begin
                     row_n   = row + RW_W'(1);
                     state_n = S_SET_ADDR;
                  end
               end else begin
                  col_n = col + CW_W'(1);
               end
            end
         end
         S_FRAME_END: begin
            phase_n = phase ^ blink_en;
            state_n = S_FRAME_WAIT;
         end
         S_FRAME_WAIT: begin
            if (!enable) begin
               state_n = S_IDLE;
            end else if (periodic) begin
               if (ref_cnt == REF_W'(REF_LAST)) start = 1'b1;
               else ref_cnt_n = ref_cnt + REF_W'(1);
            end else if (pending) begin
               start = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (start) begin
         state_n   = REINIT_EVERY_FRAME ? S_FUNCTION_SET : S_SET_ADDR;
         pending_n = refresh_req;
      end

      // Command bytes are prepared for the state being entered so db and the pulse align
      idx_n  = AW'(32'(row_n) * COLS + 32'(col_n));
      char_n = (blink_en && phase && (idx_n == cursor_pos)) ? CURSOR_CHAR : mem[idx_n];
      case (2'(row_n))
         2'd0:    base_n = 7'h00;
         2'd1:    base_n = 7'h40;
         2'd2:    base_n = 7'(COLS);
         default: base_n = 7'(64 + COLS);
      endcase

      issue = (state_n inside {S_FUNCTION_SET, S_ENTRY_MODE_SET, S_DISPLAY_ON_OFF,
                               S_CLEAR_DISPLAY, S_SET_ADDR, S_WRITE_CHAR})
              && ((state_n != state) || (state == S_WRITE_CHAR && accept));
      ni_n = issue;
      db_n = db;
      if (issue) begin
         case (state_n)
            S_FUNCTION_SET:   db_n = (ROWS > 1) ? 10'h038 : 10'h030;
            S_ENTRY_MODE_SET: db_n = 10'h006;
            S_DISPLAY_ON_OFF: db_n = 10'h00C;
            S_CLEAR_DISPLAY:  db_n = 10'h001;
            S_SET_ADDR:       db_n = {3'b001, base_n};
            default:          db_n = {2'b10, char_n};
         endcase
      end

      busy_n = !(state_n inside {S_IDLE, S_FRAME_END, S_FRAME_WAIT});
      fd_n   = (state_n == S_FRAME_END);
   end

endmodule

// File: tb/tb_lcd_display_sequencer.sv
// Directed bench: two sequencer instances (2x4 and 4x20) each driven by a writer model
// that returns done three cycles after every next_instruction pulse.
module tb_lcd_display_sequencer;

   typedef struct { logic [9:0] db; int gap; } vec_t;
   typedef struct { logic [9:0] db; int cyc; } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0;
   logic       enable_a = 1'b0, enable_b = 1'b0;
   logic       periodic = 1'b0, refresh_req = 1'b0, blink_en = 1'b0;
   logic [2:0] cursor_pos = 3'd0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = 3'd0;
   logic [7:0] wr_data = 8'd0;
   logic       wdone_a = 1'b0, wdone_b = 1'b0, force_done = 1'b0;
   logic       done_a;
   logic       ni_a, ni_b, busy_a, busy_b, fd_a, fd_b;
   logic [9:0] db_a, db_b;

   assign done_a = wdone_a | force_done;

   lcd_display_sequencer #(.CLK_HZ(1000000), .COLS(4), .ROWS(2), .CLEAR_WAIT_US(10)) dut_a (
      .clk(clk), .reset(reset), .enable(enable_a), .periodic(periodic),
      .refresh_req(refresh_req), .blink_en(blink_en), .cursor_pos(cursor_pos),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done_a),
      .next_instruction(ni_a), .db(db_a), .busy(busy_a), .frame_done(fd_a));

   lcd_display_sequencer #(.CLK_HZ(1000000), .COLS(20), .ROWS(4), .CLEAR_WAIT_US(10)) dut_b (
      .clk(clk), .reset(reset), .enable(enable_b), .periodic(1'b0),
      .refresh_req(1'b0), .blink_en(1'b0), .cursor_pos(7'd0),
      .wr_en(1'b0), .wr_addr(7'd0), .wr_data(8'd0), .done(wdone_b),
      .next_instruction(ni_b), .db(db_b), .busy(busy_b), .frame_done(fd_b));

   int   cyc = 0, dly_a = 0, dly_b = 0, fd_cnt_a = 0, fd_cnt_b = 0;
   ent_t log_a[$], log_b[$];
   vec_t exp_q[$];
   int   total = 0, passed = 0;
   logic [7:0] tb_mem [8];

   // Writer models and pulse logs, all sampled on the falling edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      wdone_a <= 1'b0;
      wdone_b <= 1'b0;
      if (!reset) dly_a <= 0;
      else if (ni_a) dly_a <= 3;
      else if (dly_a != 0) begin dly_a <= dly_a - 1; if (dly_a == 1) wdone_a <= 1'b1; end
      if (!reset) dly_b <= 0;
      else if (ni_b) dly_b <= 3;
      else if (dly_b != 0) begin dly_b <= dly_b - 1; if (dly_b == 1) wdone_b <= 1'b1; end
      if (ni_a) log_a.push_back(ent_t'{db_a, cyc});
      if (ni_b) log_b.push_back(ent_t'{db_b, cyc});
      if (fd_a) fd_cnt_a = fd_cnt_a + 1;
      if (fd_b) fd_cnt_b = fd_cnt_b + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic add(input logic [9:0] d, input int g);
      exp_q.push_back(vec_t'{d, g});
   endtask

   task automatic add_init();
      add(10'h038, -1); add(10'h006, 4); add(10'h00C, 4); add(10'h001, 4);
   endtask

   task automatic add_frame(input int first_gap, input bit cur5);
      logic [7:0] ch;
      add(10'h080, first_gap);
      for (int r = 0; r < 2; r++) begin
         if (r == 1) add(10'h0C0, 4);
         for (int c = 0; c < 4; c++) begin
            ch = (cur5 && (r * 4 + c) == 5) ? 8'h23 : tb_mem[r * 4 + c];
            add({2'b10, ch}, 4);
         end
      end
   endtask

   task automatic cmp_log_a(input string tag);
      check({tag, " count"}, log_a.size(), exp_q.size());
      for (int i = 0; i < log_a.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s db[%0d]", tag, i), log_a[i].db, exp_q[i].db);
         if (i > 0 && exp_q[i].gap >= 0)
            check($sformatf("%s gap[%0d]", tag, i), log_a[i].cyc - log_a[i-1].cyc, exp_q[i].gap);
      end
      log_a.delete();
      exp_q.delete();
   endtask

   task automatic wait_fd(input bit sel_b, input int target, input int budget, input string nm);
      for (int i = 0; i < budget && (sel_b ? fd_cnt_b : fd_cnt_a) < target; i++) tick();
      check(nm, sel_b ? fd_cnt_b : fd_cnt_a, target);
   endtask

   task automatic pulse_req();
      refresh_req = 1'b1;
      tick();
      refresh_req = 1'b0;
   endtask

   initial begin
      logic [9:0] addr_exp [4];
      ent_t       addr_got [$];
      addr_exp[0] = 10'h080; addr_exp[1] = 10'h0C0; addr_exp[2] = 10'h094; addr_exp[3] = 10'h0D4;
      for (int i = 0; i < 8; i++) tb_mem[i] = 8'h41 + 8'(i);

      repeat (3) tick();
      check("reset db", db_a, 10'h000);
      check("reset next_instruction", ni_a, 1'b0);
      check("reset busy", busy_a, 1'b0);
      check("reset frame_done", fd_a, 1'b0);

      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = 3'(i); wr_data = tb_mem[i];
         tick();
      end
      wr_en = 1'b0;
      reset = 1'b1;
      tick();

      // Init sequence with the 10-cycle clear wait, then the first frame
      enable_a = 1'b1;
      add_init();
      add_frame(14, 1'b0);
      wait_fd(1'b0, 1, 500, "init frame_done");
      repeat (30) tick();
      check("init single frame_done", fd_cnt_a, 1);
      check("init idle busy", busy_a, 1'b0);
      cmp_log_a("init");

      // On-demand frame, none without another request
      pulse_req();
      wait_fd(1'b0, 2, 300, "req frame_done");
      repeat (40) tick();
      check("req single frame", fd_cnt_a, 2);
      add_frame(-1, 1'b0);
      cmp_log_a("req");

      // Blinking cursor at cell 5 over two frames
      blink_en = 1'b1; cursor_pos = 3'd5;
      pulse_req();
      wait_fd(1'b0, 3, 300, "blink1 frame_done");
      add_frame(-1, 1'b1);
      cmp_log_a("blink1");
      pulse_req();
      wait_fd(1'b0, 4, 300, "blink2 frame_done");
      add_frame(-1, 1'b0);
      cmp_log_a("blink2");
      blink_en = 1'b0;

      // Two requests during a busy frame merge into one extra frame
      pulse_req();
      for (int i = 0; i < 20 && !busy_a; i++) tick();
      check("merge busy", busy_a, 1'b1);
      pulse_req();
      tick();
      pulse_req();
      wait_fd(1'b0, 6, 600, "merge frame_done");
      repeat (60) tick();
      check("merge frame count", fd_cnt_a, 6);
      add_frame(-1, 1'b0);
      add_frame(-1, 1'b0);
      cmp_log_a("merge");

      // Stray done while waiting for a frame
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      repeat (20) tick();
      check("stray done pulses", log_a.size(), 0);
      check("stray done busy", busy_a, 1'b0);
      check("stray done frames", fd_cnt_a, 6);

      // Reset in the middle of a character write
      pulse_req();
      for (int i = 0; i < 200 && log_a.size() < 3; i++) tick();
      tick();
      check("mid-frame db", db_a, 10'h242);
      #2 reset = 1'b0;
      #1;
      check("async reset db", db_a, 10'h000);
      check("async reset busy", busy_a, 1'b0);
      check("async reset next_instruction", ni_a, 1'b0);
      repeat (3) tick();
      log_a.delete();
      reset = 1'b1;
      add_init();
      add_frame(14, 1'b0);
      wait_fd(1'b0, 7, 500, "reinit frame_done");
      cmp_log_a("reinit");

      // 4x20 geometry: row base addresses
      enable_b = 1'b1;
      wait_fd(1'b1, 1, 3000, "geom frame_done");
      check("geom pulse count", log_b.size(), 4 + 4 + 80);
      foreach (log_b[i]) if (log_b[i].db[9:7] == 3'b001) addr_got.push_back(log_b[i]);
      check("geom addr count", addr_got.size(), 4);
      for (int i = 0; i < 4 && i < addr_got.size(); i++)
         check($sformatf("geom addr[%0d]", i), addr_got[i].db, addr_exp[i]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
